// File: rtl/board_io_ctrl_if.sv
// Pad-side signal bundle for board_io_ctrl: clock-enable, LED, UART RX/TX and oscillator enable.
interface board_io_ctrl_if #(
  parameter int unsigned NUM_LEDS  = 8,
  parameter int unsigned DIV_WIDTH = 5,
  parameter int unsigned PWM_WIDTH = 4
);
  logic [DIV_WIDTH-1:0] div_ratio;
  logic                 core_ce;
  logic [NUM_LEDS-1:0]  led_in;
  logic [PWM_WIDTH-1:0] led_bright;
  logic [NUM_LEDS-1:0]  led_out;
  logic                 rx_pin;
  logic                 rx_out;
  logic                 tx_in;
  logic                 tx_out;
  logic                 clken_out;

  modport master (
    output div_ratio, led_in, led_bright, rx_pin, tx_in,
    input  core_ce, led_out, rx_out, tx_out, clken_out
  );

  modport slave (
    input  div_ratio, led_in, led_bright, rx_pin, tx_in,
    output core_ce, led_out, rx_out, tx_out, clken_out
  );
endinterface

// File: rtl/board_io_ctrl.sv
// Board I/O controller: clock-enable divider, LED polarity/PWM, filtered UART RX, registered UART TX.
module board_io_ctrl #(
  parameter int unsigned          NUM_LEDS    = 8,
  parameter logic [NUM_LEDS-1:0]  LED_POL     = '1,
  parameter int unsigned          DIV_WIDTH   = 5,
  parameter int unsigned          PWM_WIDTH   = 4,
  parameter int unsigned          SYNC_STAGES = 2,
  parameter int unsigned          FILTER_LEN  = 3
) (
  input  logic          clk,
  input  logic          resetn,
  board_io_ctrl_if.slave bus
);

  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

  logic [DIV_WIDTH-1:0]   div_cnt;
  logic [PWM_WIDTH-1:0]   pwm_cnt;
  logic                   pwm_on;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_sync;
  logic [FW-1:0]          flt_cnt;

  // Full-scale brightness bypasses the compare so the LED never blinks off.
  always_comb begin
    pwm_on = 1'b0;
    if (bus.led_bright == '1) pwm_on = 1'b1;
    else                      pwm_on = (pwm_cnt < bus.led_bright);
  end

  assign rx_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      div_cnt       <= '0;
      bus.core_ce   <= 1'b0;
      pwm_cnt       <= '0;
      bus.led_out   <= LED_POL;
      sync_q        <= '1;
      bus.rx_out    <= 1'b1;
      flt_cnt       <= '0;
      bus.tx_out    <= 1'b1;
      bus.clken_out <= 1'b0;
    end else begin
      // >= rather than == so a ratio lowered mid-period wraps immediately.
      if (div_cnt >= bus.div_ratio) begin
        div_cnt     <= '0;
        bus.core_ce <= 1'b1;
      end else begin
        div_cnt     <= div_cnt + 1'b1;
        bus.core_ce <= 1'b0;
      end

      pwm_cnt     <= pwm_cnt + 1'b1;
      bus.led_out <= LED_POL ^ (bus.led_in & {NUM_LEDS{pwm_on}});

      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rx_pin};
      if (rx_sync != bus.rx_out) begin
        if (flt_cnt == FLT_LAST) begin
          bus.rx_out <= rx_sync;
          flt_cnt    <= '0;
        end else begin
          flt_cnt <= flt_cnt + 1'b1;
        end
      end else begin
        flt_cnt <= '0;
      end

      bus.tx_out    <= bus.tx_in;
      bus.clken_out <= 1'b1;
    end
  end

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed self-checking bench for board_io_ctrl with hand-computed expectations.
module tb_board_io_ctrl;

  logic clk;
  logic resetn;
  int unsigned n_cmp;
  int unsigned n_bad;

  board_io_ctrl_if #(.NUM_LEDS(8), .DIV_WIDTH(5), .PWM_WIDTH(4)) bus ();

  board_io_ctrl #(
    .NUM_LEDS(8), .LED_POL(8'hFF), .DIV_WIDTH(5), .PWM_WIDTH(4),
    .SYNC_STAGES(2), .FILTER_LEN(3)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ce(input int budget);
    int k;
    k = 0;
    while (bus.core_ce !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check("ce_seen", 32'(bus.core_ce), 32'd1);
  endtask

  initial begin
    int lows;
    logic others_ok;
    logic tx_prev;

    n_cmp = 0;
    n_bad = 0;
    resetn = 1'b0;
    bus.div_ratio = 5'd3;
    bus.led_in = 8'h00;
    bus.led_bright = 4'd0;
    bus.rx_pin = 1'b1;
    bus.tx_in = 1'b0;

    repeat (3) tick();
    check("rst_ce", 32'(bus.core_ce), 32'd0);
    check("rst_led", 32'(bus.led_out), 32'hFF);
    check("rst_rx", 32'(bus.rx_out), 32'd1);
    check("rst_tx", 32'(bus.tx_out), 32'd1);
    check("rst_clken", 32'(bus.clken_out), 32'd0);

    // Divider at ratio 3: pulses on cycles 4,8,...,20 after release.
    resetn = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      check($sformatf("div3_c%0d", c), 32'(bus.core_ce), (c % 4 == 0) ? 32'd1 : 32'd0);
      if (c == 1) check("clken_rel", 32'(bus.clken_out), 32'd1);
    end

    bus.div_ratio = 5'd0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("div0_c%0d", c), 32'(bus.core_ce), 32'd1);
    end
    bus.div_ratio = 5'd3;

    // LED brightness 0, 15, 4 on channel 0.
    bus.led_in = 8'h01;
    bus.led_bright = 4'd0;
    tick();
    for (int c = 0; c < 16; c++) begin
      tick();
      check("led_b0", 32'(bus.led_out), 32'hFF);
    end
    bus.led_bright = 4'd15;
    tick();
    for (int c = 0; c < 16; c++) begin
      tick();
      check("led_b15", 32'(bus.led_out), 32'hFE);
    end
    bus.led_bright = 4'd4;
    tick();
    lows = 0;
    others_ok = 1'b1;
    for (int c = 0; c < 16; c++) begin
      tick();
      if (bus.led_out[0] == 1'b0) lows++;
      if (bus.led_out[7:1] !== 7'h7F) others_ok = 1'b0;
    end
    check("led_b4_duty", 32'(lows), 32'd4);
    check("led_b4_others", 32'(others_ok), 32'd1);

    // RX glitch of 2 cycles is rejected.
    bus.rx_pin = 1'b0;
    tick();
    tick();
    bus.rx_pin = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("rx_glitch_c%0d", c), 32'(bus.rx_out), 32'd1);
    end

    // RX long low: falls 5 edges after the fall, rises 5 edges after the rise.
    bus.rx_pin = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      check($sformatf("rx_fall_c%0d", c), 32'(bus.rx_out), (c >= 5) ? 32'd0 : 32'd1);
    end
    bus.rx_pin = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("rx_rise_c%0d", c), 32'(bus.rx_out), (c >= 5) ? 32'd1 : 32'd0);
    end

    // TX: one-cycle registered pass-through with a toggling input.
    for (int c = 0; c < 12; c++) begin
      tx_prev = (c % 2 == 0) ? 1'b1 : 1'b0;
      bus.tx_in = tx_prev;
      tick();
      check($sformatf("tx_c%0d", c), 32'(bus.tx_out), 32'(tx_prev));
    end

    // Reset mid-operation with divider count 2 and filter count 1.
    bus.led_bright = 4'd15;
    bus.div_ratio = 5'd3;
    wait_ce(10);
    repeat (3) tick();
    bus.rx_pin = 1'b0;
    repeat (3) tick();
    check("pre_rst_led", 32'(bus.led_out), 32'hFE);
    check("pre_rst_rx", 32'(bus.rx_out), 32'd1);
    resetn = 1'b0;
    tick();
    check("mid_rst_ce", 32'(bus.core_ce), 32'd0);
    check("mid_rst_rx", 32'(bus.rx_out), 32'd1);
    check("mid_rst_led", 32'(bus.led_out), 32'hFF);
    resetn = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("post_rst_ce_c%0d", c), 32'(bus.core_ce), (c % 4 == 0) ? 32'd1 : 32'd0);
      check($sformatf("post_rst_rx_c%0d", c), 32'(bus.rx_out), (c >= 5) ? 32'd0 : 32'd1);
    end
    bus.rx_pin = 1'b1;

    // Ratio lowered from 20 to 2 while the count is 10.
    bus.div_ratio = 5'd20;
    wait_ce(40);
    repeat (10) tick();
    bus.div_ratio = 5'd2;
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("div_drop_c%0d", c), 32'(bus.core_ce), (c % 3 == 0) ? 32'd1 : 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/board_io_ctrl.md
# board_io_ctrl

Parametrised board-level I/O controller between the pad buffers and the SoC core. It replaces the fixed ripple clock divider and hard-wired inverted LED drive with four functions: a programmable clock-enable generator, per-channel LED polarity and PWM brightness, a synchronised and glitch-filtered UART RX path, and a registered UART TX path. The core runs on `clk` qualified by `core_ce`; no derived clocks are produced.

## Interface

Parameters:
- `NUM_LEDS`, 8: number of LED channels.
- `LED_POL`, 8'hFF: per-channel output polarity; bit=1 means the pad is active-low.
- `DIV_WIDTH`, 5: width of the divider counter and `div_ratio`.
- `PWM_WIDTH`, 4: width of the PWM counter and `led_bright`.
- `SYNC_STAGES`, 2: RX synchroniser depth (≥2).
- `FILTER_LEN`, 3: consecutive synchronised cycles a new RX level must persist before it is accepted (≥1).

Ports:
- `clk`, in, 1: single clock, from the input pad buffer.
- `resetn`, in, 1: reset, synchronous, active-low.
- `div_ratio`, in, DIV_WIDTH: `core_ce` period minus one.
- `core_ce`, out, 1: single-cycle clock-enable pulse for the core.
- `led_in`, in, NUM_LEDS: logical LED state from the core; 1 = lit.
- `led_bright`, in, PWM_WIDTH: global brightness.
- `led_out`, out, NUM_LEDS: to the LED pad buffers.
- `rx_pin`, in, 1: asynchronous UART RX pad.
- `rx_out`, out, 1: filtered RX to the core.
- `tx_in`, in, 1: UART TX from the core.
- `tx_out`, out, 1: to the TX pad.
- `clken_out`, out, 1: board oscillator enable.

## Operation

- Reset (`resetn`=0 at a `clk` edge) sets the following:
  - `core_ce`=0, divider count=0, PWM count=0.
  - `led_out`=LED_POL (all LEDs dark).
  - synchroniser stages=1, `rx_out`=1, filter count=0.
  - `tx_out`=1, `clken_out`=0.
- Divider: each cycle, if `cnt >= div_ratio` then `cnt<=0` and `core_ce<=1`; otherwise `cnt<=cnt+1` and `core_ce<=0`.
  - The period is `div_ratio+1` cycles, with exactly one high cycle per period.
  - `div_ratio`=0 holds `core_ce` high on every cycle.
  - If `div_ratio` is lowered below the current count mid-period, the divider wraps on the next cycle. There is no out-of-range count.
- PWM: `pwm_cnt` increments every cycle and wraps at 2^PWM_WIDTH.
  - `pwm_on` = (`led_bright`==all-ones) ? 1 : (`pwm_cnt < led_bright`).
  - 0 gives always off, all-ones gives always on, and other values give a duty of `led_bright`/2^PWM_WIDTH.
- LED: `led_out[i] <= LED_POL[i] ^ (led_in[i] & pwm_on)`, registered.
- RX path:
  - `rx_pin` passes through SYNC_STAGES flops, producing `rx_sync`.
  - Filter: if `rx_sync != rx_out`, then either update `rx_out<=rx_sync` and clear the count (when the count == FILTER_LEN-1), or increment the count.
  - If `rx_sync == rx_out`, the count clears.
  - Net effect: an excursion shorter than FILTER_LEN cycles at `rx_sync` is discarded.
- TX: `tx_out <= tx_in`.
- `clken_out <= 1` on every non-reset cycle.

## Timing

- `core_ce` first pulses after edge `div_ratio+1` following reset release (e.g. `div_ratio`=3 gives a pulse after edge 4, then every 4 cycles).
- `led_out` lags `led_in`/`pwm_on` by 1 cycle.
- `rx_pin` to `rx_out` latency is SYNC_STAGES+FILTER_LEN edges (5 at defaults) for a level held long enough.
- `tx_in` to `tx_out` latency is 1 cycle.
- `clken_out` goes to 1 one edge after reset release.
- Reset mid-operation takes effect at the next edge and overrides all state, including an RX filter count in progress and a `core_ce` pulse.
- Simultaneous events:
  - A `div_ratio` change on the wrap cycle takes effect in the next period.
  - An `rx_sync` toggle back to the `rx_out` level on the accept cycle is not accepted; the count clears.

## Test plan

- Reset, `div_ratio`=3, run 20 cycles -> `core_ce` high exactly on cycles 4, 8, 12, 16, 20 after release. Switch to `div_ratio`=0 -> `core_ce` constant 1.
- `led_in`=8'h01 with `led_bright`=0, then 15, then 4 -> `led_out[0]` constant 1, then constant 0, then 0 for 4 of every 16 cycles. Other bits constant 1 throughout.
- `rx_pin` low for 2 cycles then high -> `rx_out` stays 1. `rx_pin` low for 10 cycles -> `rx_out` falls 5 edges after the fall and rises 5 edges after the rise.
- `tx_in` toggled every cycle -> `tx_out` equals `tx_in` delayed by 1. Check `clken_out`=0 during reset and 1 one edge after release.
- Assert reset while the divider count=2 and the RX filter count=1 -> `core_ce`=0, `rx_out`=1, `led_out`=8'hFF at the next edge, and the divider restarts from 0.
- `div_ratio` changed from 20 to 2 while the count=10 -> `core_ce` pulses on the next cycle, then every 3 cycles.
